// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types for the keypad front-end.
//   key_code_t  - code of a single accepted key (or NONE)
//   col_state_t - which keypad column is currently driven
//   key_out_t   - bundle of the level outputs seen by the countdown controller
//   KEYMAP      - key code for every matrix position, indexed by {row, col}
//   decode_key  - maps a key code to the output bundle
package keypad_pkg;

  typedef enum logic [3:0] {
    KEY_NONE,
    KEY_D0, KEY_D1, KEY_D2, KEY_D3, KEY_D4,
    KEY_D5, KEY_D6, KEY_D7, KEY_D8, KEY_D9,
    KEY_START,
    KEY_CLEAR,
    KEY_CONFIRM,
    KEY_IGNORED
  } key_code_t;

  typedef enum logic [1:0] {
    COL0,
    COL1,
    COL2,
    COL3
  } col_state_t;

  typedef struct packed {
    logic       keydown_num;
    logic [3:0] num;
    logic       keydown_start;
    logic       keydown_clear;
    logic       keydown_confirm;
  } key_out_t;

  // Row-major: entry 4*r + c is the key at row r, column c.
  // *, # and D are real keys for multi-key detection but drive nothing.
  localparam key_code_t KEYMAP [16] = '{
    KEY_D1,      KEY_D2, KEY_D3,      KEY_START,
    KEY_D4,      KEY_D5, KEY_D6,      KEY_CLEAR,
    KEY_D7,      KEY_D8, KEY_D9,      KEY_CONFIRM,
    KEY_IGNORED, KEY_D0, KEY_IGNORED, KEY_IGNORED
  };

  // At most one field is ever set, so the outputs are exclusive by construction.
  function automatic key_out_t decode_key(input key_code_t code);
    key_out_t o;
    o = '0;
    if (code >= KEY_D0 && code <= KEY_D9) begin
      o.keydown_num = 1'b1;
      o.num         = 4'(code) - 4'(KEY_D0);
    end else begin
      case (code)
        KEY_START:   o.keydown_start   = 1'b1;
        KEY_CLEAR:   o.keydown_clear   = 1'b1;
        KEY_CONFIRM: o.keydown_confirm = 1'b1;
        default:     o = '0;
      endcase
    end
    return o;
  endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad matrix pins plus the decoded key levels.
//   row   - keypad rows, active-low, driven by the keypad side
//   col   - column drive, active-low one-hot, driven by the scanner
//   keydown_num / num / keydown_start / keydown_clear / keydown_confirm
//         - accepted-key levels, driven by the scanner
// master: the scanner (keypad_scan).  slave: keypad and controller side.
interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic       keydown_num;
  logic [3:0] num;
  logic       keydown_start;
  logic       keydown_clear;
  logic       keydown_confirm;

  modport master (
    input  row,
    output col, keydown_num, num, keydown_start, keydown_clear, keydown_confirm
  );

  modport slave (
    output row,
    input  col, keydown_num, num, keydown_start, keydown_clear, keydown_confirm
  );
endinterface

// File: rtl/keypad_debounce.sv
// keypad_debounce: turns per-scan results into a stable accepted key.
//   clk, rst     - clock, synchronous active-high reset
//   scan_done    - one-cycle strobe, scan_result valid in that cycle
//   scan_result  - key code seen in the scan just completed (NONE if 0 or >1 keys)
//   acc          - currently accepted key code
// A result must repeat for DEBOUNCE consecutive scans before it is accepted.
// A direct key-to-key change passes through NONE for one scan so the
// downstream edge detector always sees a fresh rising edge.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 8
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      scan_done,
  input  key_code_t scan_result,
  output key_code_t acc
);

  localparam int              CNT_W   = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

  key_code_t        cand_reg, cand_next;
  key_code_t        acc_reg,  acc_next;
  logic [CNT_W-1:0] cnt_reg,  cnt_next;

  always_comb begin
    cand_next = cand_reg;
    cnt_next  = cnt_reg;
    acc_next  = acc_reg;
    if (scan_done) begin
      if (scan_result == cand_reg) begin
        if (cnt_reg != CNT_MAX) begin
          cnt_next = cnt_reg + 1'b1;
        end
      end else begin
        cand_next = scan_result;
        cnt_next  = CNT_W'(1);
      end
      // Decision uses the count including this scan, so a result seen in
      // DEBOUNCE consecutive scans is accepted at the last of them.
      if (cnt_next == CNT_MAX && cand_next != acc_reg) begin
        if (acc_reg == KEY_NONE || cand_next == KEY_NONE) begin
          acc_next = cand_next;
        end else begin
          // Key-to-key: release first; the still-stable candidate is taken
          // at the next scan end.
          acc_next = KEY_NONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand_reg <= KEY_NONE;
      cnt_reg  <= '0;
      acc_reg  <= KEY_NONE;
    end else begin
      cand_reg <= cand_next;
      cnt_reg  <= cnt_next;
      acc_reg  <= acc_next;
    end
  end

  assign acc = acc_reg;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 active-low matrix keypad scanner for the countdown controller.
//   clk, rst - clock, synchronous active-high reset
//   kif      - keypad_scan_if.master: row in, col out, accepted-key levels out
// Parameters:
//   SCAN_DIV - cycles each column is driven (>= 4)
//   DEBOUNCE - identical consecutive scans needed to accept a result (>= 1)
// Rows are synchronised, sampled at the end of each column dwell, and the
// presses of one full scan are reduced to a single key code (NONE when zero
// or several keys are down). The debouncer picks the accepted key and the
// outputs are registered from it.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 8
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scan_if.master kif
);

  localparam int               DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // ---------------------------------------------------------------- row sync
  logic [3:0] row_meta_reg;
  logic [3:0] row_sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_reg <= 4'b1111;
      row_sync_reg <= 4'b1111;
    end else begin
      row_meta_reg <= kif.row;
      row_sync_reg <= row_meta_reg;
    end
  end

  // ------------------------------------------------- divider / column FSM
  col_state_t       state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [3:0]       col_reg;
  logic             sample_en;
  logic             scan_done;
  logic [1:0]       col_idx;

  // Sampling on the last dwell cycle leaves at least SCAN_DIV-1 >= 3 cycles
  // after the column change for the synchroniser to settle.
  assign sample_en = (div_reg == DIV_LAST);
  assign scan_done = sample_en && (state_reg == COL3);
  assign col_idx   = state_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= COL0;
      div_reg   <= '0;
      col_reg   <= 4'b1110;
    end else if (sample_en) begin
      div_reg <= '0;
      case (state_reg)
        COL0: begin
          state_reg <= COL1;
          col_reg   <= 4'b1101;
        end
        COL1: begin
          state_reg <= COL2;
          col_reg   <= 4'b1011;
        end
        COL2: begin
          state_reg <= COL3;
          col_reg   <= 4'b0111;
        end
        default: begin
          state_reg <= COL0;
          col_reg   <= 4'b1110;
        end
      endcase
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end

  // ------------------------------------------------ per-scan accumulation
  key_code_t  row_code [4];
  logic [3:0] row_hit;

  for (genvar gi = 0; gi < 4; gi++) begin : g_row
    assign row_hit[gi]  = ~row_sync_reg[gi];
    assign row_code[gi] = KEYMAP[{2'(gi), col_idx}];
  end

  logic [1:0] hit_cnt_reg,  hit_cnt_next;   // saturates at 2 = "many"
  key_code_t  hit_code_reg, hit_code_next;
  logic [2:0] col_cnt;
  logic [2:0] hit_total;
  key_code_t  col_code;
  key_code_t  scan_result;

  always_comb begin
    col_cnt  = '0;
    col_code = KEY_NONE;
    for (int r = 0; r < 4; r++) begin
      if (row_hit[r]) begin
        col_cnt  = col_cnt + 3'd1;
        col_code = row_code[r];
      end
    end
    hit_total     = {1'b0, hit_cnt_reg} + col_cnt;
    hit_cnt_next  = (hit_total >= 3'd2) ? 2'd2 : hit_total[1:0];
    // The code only matters when exactly one key was seen in the whole scan.
    hit_code_next = (col_cnt != 3'd0) ? col_code : hit_code_reg;
    scan_result   = (hit_cnt_next == 2'd1) ? hit_code_next : KEY_NONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_reg  <= '0;
      hit_code_reg <= KEY_NONE;
    end else if (sample_en) begin
      if (scan_done) begin
        hit_cnt_reg  <= '0;
        hit_code_reg <= KEY_NONE;
      end else begin
        hit_cnt_reg  <= hit_cnt_next;
        hit_code_reg <= hit_code_next;
      end
    end
  end

  // ------------------------------------------------------------- debounce
  key_code_t acc;

  keypad_debounce #(
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk         (clk),
    .rst         (rst),
    .scan_done   (scan_done),
    .scan_result (scan_result),
    .acc         (acc)
  );

  // ------------------------------------------------------- output register
  key_out_t out_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= '0;
    end else begin
      out_reg <= decode_key(acc);
    end
  end

  assign kif.col             = col_reg;
  assign kif.keydown_num     = out_reg.keydown_num;
  assign kif.num             = out_reg.num;
  assign kif.keydown_start   = out_reg.keydown_start;
  assign kif.keydown_clear   = out_reg.keydown_clear;
  assign kif.keydown_confirm = out_reg.keydown_confirm;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: self-checking bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=3).
// A matrix model turns the pressed-key set into row levels from the driven
// column. A scan-level reference model applies the debounce/accept rules to
// key classes and predicts every output and column value cycle by cycle.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 3;
  localparam int T  = 4 * SD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] keys = '0;
  logic [3:0]  row_drv;

  int checks  = 0;
  int errors  = 0;
  int phase   = 0;
  int cyc_bad = 0;
  int bad_ph  = 0;
  logic [7:0] bad_obs = '0;
  logic [7:0] bad_exp = '0;
  logic [7:0] exp_out = '0;
  logic [3:0] exp_col = 4'b1110;
  logic [7:0] m_cand = "N";
  logic [7:0] m_acc  = "N";
  int         m_cnt  = 0;
  bit         any_seen = 1'b0;
  string      km = "123A456B789C*0#D";

  always #5 clk = ~clk;

  keypad_scan_if kif ();
  assign kif.row = row_drv;

  keypad_scan #(
    .SCAN_DIV (SD),
    .DEBOUNCE (DB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif)
  );

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row_drv = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kif.col[c]) row_drv[r] = 1'b0;
      end
    end
  end

  function automatic logic [7:0] obs_out();
    return {kif.keydown_num, kif.num, kif.keydown_start, kif.keydown_clear, kif.keydown_confirm};
  endfunction

  // Class of a full scan: N = none or several keys, I = ignored key, else the key label.
  function automatic logic [7:0] key_class(input logic [15:0] k);
    logic [7:0] ch;
    int idx;
    idx = 0;
    if ($countones(k) != 1) return "N";
    for (int i = 0; i < 16; i++) if (k[i]) idx = i;
    ch = km[idx];
    if (ch == "*" || ch == "#" || ch == "D") return "I";
    return ch;
  endfunction

  function automatic logic [7:0] exp_of(input logic [7:0] a);
    if (a >= "0" && a <= "9") return {1'b1, 4'(a - 8'h30), 3'b000};
    if (a == "A") return 8'b0000_0100;
    if (a == "B") return 8'b0000_0010;
    if (a == "C") return 8'b0000_0001;
    return 8'h00;
  endfunction

  function automatic void model_scan(input logic [7:0] res);
    if (res == m_cand) begin
      if (m_cnt < DB) m_cnt++;
    end else begin
      m_cand = res;
      m_cnt  = 1;
    end
    if (m_cnt == DB && m_cand != m_acc)
      m_acc = (m_acc == "N" || m_cand == "N") ? m_cand : "N";
  endfunction

  function automatic void model_reset();
    m_cand = "N";
    m_cnt  = 0;
    m_acc  = "N";
    phase  = 0;
  endfunction

  // One clock: advance the model at the edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    phase++;
    exp_out = exp_of(m_acc);
    exp_col = ~(4'b0001 << ((phase / SD) % 4));
    if (phase % T == 0) model_scan(key_class(keys));
    @(negedge clk);
    if (obs_out() != 8'h00) any_seen = 1'b1;
    if (obs_out() !== exp_out || kif.col !== exp_col ||
        $countones({kif.keydown_num, kif.keydown_start, kif.keydown_clear, kif.keydown_confirm}) > 1) begin
      if (cyc_bad == 0) begin
        bad_ph  = phase;
        bad_obs = obs_out();
        bad_exp = exp_out;
      end
      cyc_bad++;
    end
  endtask

  task automatic hold(input logic [15:0] k, input int n);
    keys = k;
    repeat (n * T) tick();
    $display("[%0t] keys=%04h scans=%0d out=%02h model_acc=%s", $time, k, n, obs_out(), m_acc);
  endtask

  task automatic align();
    while (phase % T != 0) tick();
  endtask

  // Tick until (out & mask) != 0 equals level, bounded by 8 scans.
  task automatic wait_out(input logic [7:0] mask, input bit level, output int lat, output bit ok);
    int t0;
    t0 = phase;
    ok = 1'b0;
    for (int i = 0; i < 8 * T; i++) begin
      tick();
      if (((obs_out() & mask) != 8'h00) == level) begin
        ok = 1'b1;
        break;
      end
    end
    lat = phase - t0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_out() !== 8'h00) begin
      errors++; $display("FAIL reset_out: got %02h want 00", obs_out());
    end
    checks++;
    if (kif.col !== 4'b1110) begin
      errors++; $display("FAIL reset_col: got %b want 1110", kif.col);
    end
    rst = 1'b0;
    model_reset();
    cyc_bad = 0;
    for (int i = 0; i < T; i++) begin
      tick();
      if (phase == 12) begin
        checks++;
        if (kif.col !== 4'b0111) begin
          errors++; $display("FAIL col_at_12: got %b want 0111", kif.col);
        end
      end
      if (phase == 16) begin
        checks++;
        if (kif.col !== 4'b1110) begin
          errors++; $display("FAIL col_wrap_16: got %b want 1110", kif.col);
        end
      end
    end
    checks++;
    if (cyc_bad !== 0) begin
      errors++; $display("FAIL reset_model: %0d bad cycles, first phase %0d got %02h want %02h", cyc_bad, bad_ph, bad_obs, bad_exp);
    end
    cyc_bad = 0;
    $display("[%0t] reset checked", $time);
  endtask

  task automatic test_single_press();
    int  lat;
    bit  ok;
    keys = 16'(1) << 8;  // key 7
    wait_out(8'h80, 1'b1, lat, ok);
    checks++;
    if (!ok || lat < 3 * T || lat > 4 * T + 1 || kif.num !== 4'd7) begin
      errors++; $display("FAIL press7: ok=%0d lat=%0d num=%0d want lat 48..65 num 7", ok, lat, kif.num);
    end
    align();
    hold(16'(1) << 8, 6);
    keys = '0;
    wait_out(8'h80, 1'b0, lat, ok);
    checks++;
    if (!ok || lat < 3 * T || lat > 4 * T + 1 || kif.num !== 4'd0) begin
      errors++; $display("FAIL release7: ok=%0d lat=%0d num=%0d want lat 48..65 num 0", ok, lat, kif.num);
    end
    align();
    hold('0, 2);
    checks++;
    if (cyc_bad !== 0) begin
      errors++; $display("FAIL single_model: %0d bad cycles, first phase %0d got %02h want %02h", cyc_bad, bad_ph, bad_obs, bad_exp);
    end
    cyc_bad = 0;
  endtask

  task automatic test_bounce();
    any_seen = 1'b0;
    hold(16'(1) << 5, 2);
    hold('0, 1);
    hold(16'(1) << 5, 2);
    hold('0, 4);
    checks++;
    if (any_seen !== 1'b0) begin
      errors++; $display("FAIL bounce_quiet: got output activity, want none");
    end
    checks++;
    if (cyc_bad !== 0) begin
      errors++; $display("FAIL bounce_model: %0d bad cycles, first phase %0d got %02h want %02h", cyc_bad, bad_ph, bad_obs, bad_exp);
    end
    cyc_bad = 0;
  endtask

  task automatic test_multi_key();
    int lat;
    bit ok;
    any_seen = 1'b0;
    hold(16'b0000_0000_0000_0011, 6);  // keys 1 and 2
    checks++;
    if (any_seen !== 1'b0) begin
      errors++; $display("FAIL multi_quiet: got output activity, want none");
    end
    keys = 16'b0000_0000_0000_0001;
    wait_out(8'h80, 1'b1, lat, ok);
    checks++;
    if (!ok || lat != 3 * T + 1 || kif.num !== 4'd1) begin
      errors++; $display("FAIL multi_release2: ok=%0d lat=%0d num=%0d want lat 49 num 1", ok, lat, kif.num);
    end
    align();
    hold('0, 5);
    checks++;
    if (cyc_bad !== 0) begin
      errors++; $display("FAIL multi_model: %0d bad cycles, first phase %0d got %02h want %02h", cyc_bad, bad_ph, bad_obs, bad_exp);
    end
    cyc_bad = 0;
  endtask

  task automatic test_key_to_key();
    int         src  [3] = '{3, 7, 11};          // A, B, C
    logic [7:0] want [3] = '{8'h04, 8'h02, 8'h01};
    int lat, tf, gap;
    bit ok1, ok2;
    for (int i = 0; i < 3; i++) begin
      hold(16'(1) << src[i], 4);
      checks++;
      if (obs_out() !== want[i]) begin
        errors++; $display("FAIL k2k_src%0d: got %02h want %02h", i, obs_out(), want[i]);
      end
      keys = 16'(1) << 5;
      wait_out(8'hFF, 1'b0, lat, ok1);
      tf = phase;
      wait_out(8'h80, 1'b1, lat, ok2);
      gap = phase - tf;
      checks++;
      if (!ok1 || !ok2 || gap != T || kif.num !== 4'd5) begin
        errors++; $display("FAIL k2k_gap%0d: ok=%0d/%0d gap=%0d num=%0d want gap 16 num 5", i, ok1, ok2, gap, kif.num);
      end
      align();
      hold('0, 5);
    end
    checks++;
    if (cyc_bad !== 0) begin
      errors++; $display("FAIL k2k_model: %0d bad cycles, first phase %0d got %02h want %02h", cyc_bad, bad_ph, bad_obs, bad_exp);
    end
    cyc_bad = 0;
  endtask

  task automatic test_ignored_and_reset();
    int lat;
    bit ok;
    any_seen = 1'b0;
    hold(16'(1) << 14, 5);                       // #
    hold((16'(1) << 14) | (16'(1) << 2), 5);     // # + 3
    hold('0, 4);
    checks++;
    if (any_seen !== 1'b0) begin
      errors++; $display("FAIL ignored_quiet: got output activity, want none");
    end
    hold(16'(1) << 2, 5);
    checks++;
    if (obs_out() !== 8'b1_0011_000) begin
      errors++; $display("FAIL hold3: got %02h want 98", obs_out());
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_out() !== 8'h00 || kif.col !== 4'b1110) begin
      errors++; $display("FAIL midreset: out=%02h col=%b want 00 1110", obs_out(), kif.col);
    end
    rst = 1'b0;
    model_reset();
    wait_out(8'h80, 1'b1, lat, ok);
    checks++;
    if (!ok || phase != 3 * T + 1 || kif.num !== 4'd3) begin
      errors++; $display("FAIL reaccept3: ok=%0d phase=%0d num=%0d want 49 3", ok, phase, kif.num);
    end
    align();
    hold(16'(1) << 2, 2);
    hold('0, 5);
    checks++;
    if (cyc_bad !== 0) begin
      errors++; $display("FAIL ignored_model: %0d bad cycles, first phase %0d got %02h want %02h", cyc_bad, bad_ph, bad_obs, bad_exp);
    end
    cyc_bad = 0;
  endtask

  task automatic test_random();
    logic [15:0] k;
    int a, b, kind;
    k = '0;
    for (int s = 0; s < 40; s++) begin
      kind = $urandom_range(0, 3);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      case (kind)
        0: k = '0;
        1: k = 16'(1) << a;
        2: k = (16'(1) << a) | (16'(1) << b);
        default: k = k;
      endcase
      hold(k, $urandom_range(1, 5));
      checks++;
      if (cyc_bad !== 0) begin
        errors++; $display("FAIL random_seg%0d: %0d bad cycles, first phase %0d got %02h want %02h", s, cyc_bad, bad_ph, bad_obs, bad_exp);
      end
      cyc_bad = 0;
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_multi_key();
    test_key_to_key();
    test_ignored_and_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Front-end for the countdown controller. Scans a 4x4 active-low matrix keypad, synchronises and debounces it, and rejects multi-key presses. Produces the level signals `keydown_num`, `num`, `keydown_start`, `keydown_clear` and `keydown_confirm`, which the controller edge-detects, and guarantees that at most one of these outputs is high at any time.

## Interface

Parameters:
- `SCAN_DIV`, default 50000: clk cycles each column is driven. Must be at least 4.
- `DEBOUNCE`, default 8: consecutive identical full scans required before a result is accepted. Must be at least 1.

Ports:
- `clk` input, 1: system clock, single clock domain.
- `rst` input, 1: synchronous, active-high reset.
- `row` input, 4: keypad rows, active-low (pulled up), asynchronous to `clk`.
- `col` output, 4: column drive, active-low one-hot.
- `keydown_num` output, 1: a digit key is accepted.
- `num` output, 4: digit value (0–9) while `keydown_num` is 1; otherwise 0.
- `keydown_start` output, 1: key A is accepted.
- `keydown_clear` output, 1: key B is accepted.
- `keydown_confirm` output, 1: key C is accepted.

## Operation

- **Keymap** (row r, column c):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - Keys `*`, `#` and D are IGNORED. They count as pressed for multi-key detection but drive no output.
- **Row sync.** `row` passes through a 2-flop synchroniser before any use.
- **Column scan.** `col` steps through 1110, 1101, 1011, 0111, then wraps. A divider holds each column for `SCAN_DIV` cycles. Synchronised rows are sampled on the last cycle of each dwell.
- **Scan result.** At the end of column 3:
  - 0 keys pressed: the result is NONE.
  - Exactly 1 key pressed: the result is that key's code.
  - 2 or more keys pressed: the result is NONE (multi-key rejected).
- **Debounce.** State is `cand` and `cnt` (saturating at `DEBOUNCE`). At each scan end:
  - If result == `cand`: `cnt`++.
  - Otherwise: `cand` = result and `cnt` = 1.
- **Accept rule.** Applies when `cnt` == `DEBOUNCE` and `cand` != `acc`:
  - If `acc` is NONE or `cand` is NONE: `acc` = `cand`.
  - If both are keys (direct key-to-key change): `acc` = NONE first. At the next scan end, `cand` is still stable, so `acc` = `cand`. This forces a gap of one scan period, so the controller sees a fresh rising edge.
- **Output decode.** Outputs are registered from `acc`. `num` and `keydown_num` update in the same cycle.

## Timing

- **Reset values.**
  - `col` = 1110, divider = 0, synchroniser flops = 1111.
  - `cand` = NONE, `cnt` = 0, `acc` = NONE.
  - All keydown outputs = 0, `num` = 0.
- **Scan period.** T = 4·`SCAN_DIV` cycles. The first scan completes 4·`SCAN_DIV` cycles after `rst` deasserts.
- **Latency.** Outputs change 1 cycle after the scan end at which `acc` changes.
  - Press or release latency: between `DEBOUNCE`·T and (`DEBOUNCE`+1)·T, plus 1 cycle.
- **Key-to-key change.** Exactly T cycles with all outputs 0 between the old key and the new key.
- **Bounce.** A result that is stable for fewer than `DEBOUNCE` scans never changes `acc`.
- **Reset mid-press.** Outputs are 0 in the cycle after `rst` is sampled high. A held key is re-accepted after `DEBOUNCE` full scans.
- **Exclusivity.** Outputs are mutually exclusive in every cycle.
- **Row sampling.** The sample is taken at least 3 cycles after the column change, so the synchroniser has settled.

## Structure

- **`keypad_pkg`** holds:
  - The key-code enum: NONE, D0–D9, START, CLEAR, CONFIRM, IGNORED.
  - The 16-entry keymap constant indexed by {r, c}.
  - The decode function from key code to outputs.
- **Sub-module `keypad_debounce`** contains `cand`, `cnt`, `acc` and the accept rule. It takes the scan result plus a one-cycle `scan_done` strobe and outputs `acc`.
- **Top level** contains the synchroniser, the divider/column FSM, the per-scan pressed-key accumulation (key code plus count) and the output register.

## Test plan

All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=3, so T = 16 cycles.

- **Reset.** Assert `rst` for 3 cycles. Then `col` = 1110 and all outputs are 0; `col` reaches 0111 at cycle 12 after release and wraps to 1110 at cycle 16.
- **Single press.**
  - Hold key 7 (r2 low while `col` = 1110) for 10 scans: `keydown_num` = 1 and `num` = 7, asserted within 3T–4T+1 cycles of press.
  - Release: both return to 0 within the same bound.
- **Bounce.** Key 5 pressed for 2 scans, released for 1 scan, pressed for 2 scans, then released: no output ever asserts.
- **Multi-key.**
  - Hold 1 and 2 together for 6 scans: all outputs stay 0.
  - Release 2: `keydown_num` = 1 and `num` = 1 after 3 stable scans.
- **Key-to-key change.** Hold A until `keydown_start` = 1, then switch directly to 5: `keydown_start` falls, all outputs are 0 for exactly 16 cycles, then `keydown_num` = 1 and `num` = 5. Also check `keydown_clear` with B and `keydown_confirm` with C.
- **Ignored key and reset mid-press.**
  - Key # alone produces no outputs; # plus 3 together produces no outputs.
  - While 3 is accepted, pulse `rst` for 1 cycle: outputs are 0 on the next cycle and reassert after 3 full scans.
